// File: rtl/mips_pipe3.sv
// mips_pipe3: three-stage (F, D, E) pipelined MIPS-style datapath with E->D forwarding and BEQ flush.
// Optional performance counters (retire_count, stall_count) are built when MIPS_PERF_CNT_EN is defined.
module mips_pipe3 #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 6,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              overflow,
    output logic              carry,
    output logic              equal,
    output logic [PC_W-1:0]   retire_pc,
    output logic [31:0]       retire_count,
    output logic [31:0]       stall_count
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [PC_W-1:0] PC0 = PC_W'(RESET_PC);

    logic [PC_W-1:0]   pc, d_pc, e_pc, e_off;
    logic [31:0]       d_ins;
    logic              d_valid, e_valid, e_wr, taken;
    logic [3:0]        d_op, e_op;
    logic [5:0]        d_rs, d_rt, e_rd;
    logic [DATA_W-1:0] d_a, d_rt_val, d_b, d_imm, e_a, e_b;
    logic [DATA_W-1:0] regs [64];
    logic [DATA_W-1:0] alu_y;
    logic              alu_c, alu_v;
    logic [DATA_W:0]   sum, dif;

    assign imem_addr = pc;
    assign d_op      = d_ins[30:27];
    assign d_rs      = d_ins[20:15];
    assign d_rt      = d_ins[14:9];
    assign d_imm     = {{(DATA_W-15){d_ins[14]}}, d_ins[14:0]};
    assign e_wr      = e_valid && e_op < 4'd12;
    assign d_a       = (e_wr && e_rd == d_rs) ? alu_y : regs[d_rs];
    assign d_rt_val  = (e_wr && e_rd == d_rt) ? alu_y : regs[d_rt];
    assign d_b       = (d_ins[31] && d_op != 4'd15) ? d_imm : d_rt_val;
    assign taken     = e_valid && e_op == 4'd15 && e_a == e_b;
    assign sum       = {1'b0, e_a} + {1'b0, e_b};
    assign dif       = {1'b0, e_a} + {1'b0, ~e_b} + (DATA_W+1)'(1);

    // execute-stage ALU; carry of SUB is the no-borrow bit of A + ~B + 1
    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (e_op)
            4'd0: begin
                alu_y = sum[DATA_W-1:0];
                alu_c = sum[DATA_W];
                alu_v = (e_a[DATA_W-1] == e_b[DATA_W-1]) && (sum[DATA_W-1] != e_a[DATA_W-1]);
            end
            4'd1: begin
                alu_y = dif[DATA_W-1:0];
                alu_c = dif[DATA_W];
                alu_v = (e_a[DATA_W-1] != e_b[DATA_W-1]) && (dif[DATA_W-1] != e_a[DATA_W-1]);
            end
            4'd2:    alu_y = e_a & e_b;
            4'd3:    alu_y = e_a | e_b;
            4'd4:    alu_y = e_a ^ e_b;
            4'd5:    alu_y = ~(e_a | e_b);
            4'd6:    alu_y = e_a << e_b[SH_W-1:0];
            4'd7:    alu_y = e_a >> e_b[SH_W-1:0];
            4'd8:    alu_y = $signed(e_a) >>> e_b[SH_W-1:0];
            4'd9:    alu_y = {{(DATA_W-1){1'b0}}, $signed(e_a) < $signed(e_b)};
            4'd10:   alu_y = {{(DATA_W-1){1'b0}}, e_a < e_b};
            4'd11:   alu_y = e_b;
            default: alu_y = '0;
        endcase
    end

    // fetch: advance on valid memory data, redirect on a taken branch, bubble otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= PC0;
            d_valid <= 1'b0;
            d_pc    <= '0;
            d_ins   <= '0;
        end else begin
            d_valid <= imem_valid && !taken;
            if (taken)
                pc <= e_pc + e_off;
            else if (imem_valid)
                pc <= pc + PC_W'(1);
            if (imem_valid) begin
                d_ins <= imem_rdata;
                d_pc  <= pc;
            end
        end
    end

    // decode to execute: latch forwarded operands; a taken branch squashes the decoded instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid <= 1'b0;
            e_op    <= '0;
            e_rd    <= '0;
            e_a     <= '0;
            e_b     <= '0;
            e_pc    <= '0;
            e_off   <= '0;
        end else begin
            e_valid <= d_valid && !taken;
            e_op    <= d_op;
            e_rd    <= d_ins[26:21];
            e_a     <= d_a;
            e_b     <= d_b;
            e_pc    <= d_pc;
            e_off   <= PC_W'({{PC_W{d_ins[14]}}, d_ins[14:0]});
        end
    end

    // writeback: register file update and retire-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++)
                regs[i] <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            carry        <= 1'b0;
            equal        <= 1'b0;
            retire_pc    <= '0;
        end else begin
            result_valid <= e_wr;
            if (e_wr)
                regs[e_rd] <= alu_y;
            if (e_valid) begin
                result    <= alu_y;
                overflow  <= alu_v;
                carry     <= alu_c;
                equal     <= e_a == e_b;
                retire_pc <= e_pc;
            end
        end
    end

`ifdef MIPS_PERF_CNT_EN
    // retired-instruction and fetch-stall counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count <= '0;
            stall_count  <= '0;
        end else begin
            retire_count <= retire_count + 32'(e_valid);
            stall_count  <= stall_count + 32'(!imem_valid);
        end
    end
`else
    assign retire_count = '0;
    assign stall_count  = '0;
`endif
endmodule
